// File: rtl/sdram_host_arb_if.sv
// ---------------------------------------------------------------------------
// sdram_host_arb_if
// Bundles the requester-side and SdramCont-side signals of sdram_host_arb.
//   Port A (CPU)      : AReq, AWr, AAddr[22:0]  -> arbiter ; AAck  <- arbiter
//   Port B (DMA/video): BReq, BWr, BAddr[22:0]  -> arbiter ; BAck  <- arbiter
//   Shared return     : RdData[15:0], SelB      <- arbiter
//   SdramCont host    : HAddr[22:0], HEn, HRd, HWr, HIdle <- arbiter
//                       HDataRd[15:0]                     -> arbiter
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding logic (requesters plus SdramCont)
// ---------------------------------------------------------------------------
interface sdram_host_arb_if;
  logic        AReq;
  logic        AWr;
  logic [22:0] AAddr;
  logic        AAck;
  logic        BReq;
  logic        BWr;
  logic [22:0] BAddr;
  logic        BAck;
  logic [15:0] RdData;
  logic        SelB;
  logic [22:0] HAddr;
  logic        HEn;
  logic        HRd;
  logic        HWr;
  logic        HIdle;
  logic [15:0] HDataRd;

  modport slave (
    input  AReq, AWr, AAddr, BReq, BWr, BAddr, HDataRd,
    output AAck, BAck, RdData, SelB, HAddr, HEn, HRd, HWr, HIdle
  );

  modport master (
    output AReq, AWr, AAddr, BReq, BWr, BAddr, HDataRd,
    input  AAck, BAck, RdData, SelB, HAddr, HEn, HRd, HWr, HIdle
  );
endinterface

// File: rtl/sdram_host_arb.sv
// ---------------------------------------------------------------------------
// sdram_host_arb
// Shares the single SdramCont host port between port A (CPU) and port B
// (DMA/video). Each access holds HEn for ACCESS_CYCLES cycles, then the owner
// gets a one-cycle Ack with read data on RdData. Every REFRESH_INTERVAL cycles
// a refresh window of REFRESH_CYCLES cycles is forced (HEn low, HIdle high).
//
// Ports:
//   RClk    in  clock
//   HReset  in  synchronous active-high reset
//   bus     sdram_host_arb_if.slave (requester ports A/B, RdData, SelB,
//           SdramCont host signals HAddr/HEn/HRd/HWr/HIdle/HDataRd)
//
// Configuration macro:
//   SDRAMARB_RR_EN  defined   -> round-robin between A and B
//                   undefined -> fixed priority, A over B
// ---------------------------------------------------------------------------
module sdram_host_arb #(
  parameter int unsigned ACCESS_CYCLES    = 4,
  parameter int unsigned REFRESH_INTERVAL = 1560,
  parameter int unsigned REFRESH_CYCLES   = 8,
  parameter int unsigned CNT_W            = 12
) (
  input  logic              RClk,
  input  logic              HReset,
  sdram_host_arb_if.slave   bus
);

  localparam int unsigned PH_MAX = (ACCESS_CYCLES > REFRESH_CYCLES) ? ACCESS_CYCLES
                                                                    : REFRESH_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0]  ACC_LAST = PH_W'(ACCESS_CYCLES - 1);
  localparam logic [PH_W-1:0]  REF_LAST = PH_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(REFRESH_INTERVAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    REFRESH
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] int_cnt;
  logic             wrap;
  logic             pending;
  logic [PH_W-1:0]  phase;

  logic [22:0]      addr_q;
  logic             wr_q;
  logic             sel_b_q;
  logic             a_ack_q;
  logic             b_ack_q;
  logic [15:0]      rd_data_q;

  logic             acking;
  logic             a_elig;
  logic             b_elig;
  logic             grant_b;
  logic             start_access;
  logic             start_refresh;
  logic             finish_access;
  logic             hidle;

`ifdef SDRAMARB_RR_EN
  // 1 = favour B on the next contested grant
  logic             rr_ptr;
`endif

  assign wrap = (int_cnt == INT_LAST);

  // The Ack cycle is a turnaround: no grant is made while any Ack is out.
  // Without it the idle port would always win the Ack cycle and fixed
  // priority would degrade into alternation.
  assign acking = a_ack_q | b_ack_q;
  assign a_elig = bus.AReq & ~acking;
  assign b_elig = bus.BReq & ~acking;

`ifdef SDRAMARB_RR_EN
  assign grant_b = (a_elig & b_elig) ? rr_ptr : b_elig;
`else
  assign grant_b = b_elig & ~a_elig;
`endif

  always_comb begin
    state_next    = state;
    start_access  = 1'b0;
    start_refresh = 1'b0;
    finish_access = 1'b0;
    hidle         = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          start_refresh = 1'b1;
          state_next    = REFRESH;
        end else if (a_elig | b_elig) begin
          start_access = 1'b1;
          state_next   = ACCESS;
        end else begin
          hidle = 1'b1;
        end
      end
      ACCESS: begin
        if (phase == ACC_LAST) begin
          finish_access = 1'b1;
          state_next    = IDLE;
        end
      end
      REFRESH: begin
        hidle = 1'b1;
        if (phase == REF_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge RClk) begin
    if (HReset) begin
      state     <= IDLE;
      int_cnt   <= '0;
      pending   <= 1'b0;
      phase     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      sel_b_q   <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state   <= state_next;
      int_cnt <= wrap ? '0 : int_cnt + 1'b1;

      // A wrap wins over the clear so a wrap on the entry edge is not lost;
      // repeated wraps collapse into the single pending flag.
      if (wrap) begin
        pending <= 1'b1;
      end else if (start_refresh) begin
        pending <= 1'b0;
      end

      if (state != IDLE && state_next == state) begin
        phase <= phase + 1'b1;
      end else begin
        phase <= '0;
      end

      a_ack_q <= finish_access & ~sel_b_q;
      b_ack_q <= finish_access & sel_b_q;

      if (start_access) begin
        addr_q  <= grant_b ? bus.BAddr : bus.AAddr;
        wr_q    <= grant_b ? bus.BWr   : bus.AWr;
        sel_b_q <= grant_b;
      end

      if (finish_access && !wr_q) begin
        rd_data_q <= bus.HDataRd;
      end
    end
  end

`ifdef SDRAMARB_RR_EN
  always_ff @(posedge RClk) begin
    if (HReset) begin
      rr_ptr <= 1'b0;
    end else if (start_access) begin
      rr_ptr <= ~grant_b;
    end
  end
`endif

  assign bus.HEn    = (state == ACCESS);
  assign bus.HRd    = (state == ACCESS) & ~wr_q;
  assign bus.HWr    = (state == ACCESS) & wr_q;
  assign bus.HAddr  = addr_q;
  assign bus.SelB   = sel_b_q;
  assign bus.AAck   = a_ack_q;
  assign bus.BAck   = b_ack_q;
  assign bus.RdData = rd_data_q;
  // Combinational so SdramCont sees refresh permission in the same cycle the
  // arbiter decides it has nothing to grant; held low while in reset.
  assign bus.HIdle  = hidle & ~HReset;

endmodule
